// File: rtl/cpu_top.sv
// cpu_top: single-cycle 8-bit CPU running one of four built-in ROM programs.
//   clk            : system clock, all state updates on the rising edge
//   reset          : synchronous, active-high
//   switches[15:0] : [15:14] program select (sampled in reset), [13:7] B, [6:0] A
//   display_output : value last written by an OUT instruction
// program_counter: PC register, reloads the selected program base in reset.

module program_counter #(
    parameter int PC_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      base_sel,
    input  logic            hold,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    output logic [PC_W-1:0] pc
);
    always_ff @(posedge clk) begin
        if (reset)
            pc <= {base_sel, {(PC_W-2){1'b0}}};
        else if (!hold)
            pc <= load ? load_addr : pc + PC_W'(1);
    end
endmodule

module cpu_top #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       switches,
    output logic [DATA_W-1:0] display_output
);
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDA = 4'h1, OP_LDB = 4'h2, OP_ADD = 4'h3,
        OP_SUB  = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
        OP_MOV  = 4'h8, OP_LDI = 4'h9, OP_OUT = 4'hA, OP_BRN = 4'hB,
        OP_JMP  = 4'hC, OP_HALT = 4'hF
    } opcode_t;

    logic [PC_W-1:0]   pc;
    logic [15:0]       instruction;
    logic [3:0]        op;
    logic [2:0]        rd, rs1, rs2;
    logic [DATA_W-1:0] reg_read_data1, reg_read_data2, alu_result;
    logic [DATA_W-1:0] rf [0:7];
    logic              negative_flag, overflow, halted;
    logic              wr_en, flag_en, ovf_next;
    logic              pc_hold, pc_load;

    assign op  = instruction[15:12];
    assign rd  = instruction[11:9];
    assign rs1 = instruction[8:6];
    assign rs2 = instruction[5:3];

    // HALT holds the pc on its own address so the frozen pc points at the HALT.
    assign pc_hold = halted || (op == OP_HALT);
    assign pc_load = (op == OP_JMP) || (op == OP_BRN && negative_flag);

    program_counter #(.PC_W(PC_W)) PC (
        .clk       (clk),
        .reset     (reset),
        .base_sel  (switches[15:14]),
        .hold      (pc_hold),
        .load      (pc_load),
        .load_addr (instruction[PC_W-1:0]),
        .pc        (pc)
    );

    always_comb begin
        instruction = 16'h0000;
        case (pc)
            // sel 00: A+B
            6'd0:  instruction = 16'h1200;   // LDA r1
            6'd1:  instruction = 16'h2400;   // LDB r2
            6'd2:  instruction = 16'h3650;   // ADD r3,r1,r2
            6'd3:  instruction = 16'hA0C0;   // OUT r3
            6'd4:  instruction = 16'hF000;   // HALT
            // sel 01: A-B
            6'd16: instruction = 16'h1200;
            6'd17: instruction = 16'h2400;
            6'd18: instruction = 16'h4650;   // SUB r3,r1,r2
            6'd19: instruction = 16'hA0C0;
            6'd20: instruction = 16'hF000;
            // sel 10: A^B
            6'd32: instruction = 16'h1200;
            6'd33: instruction = 16'h2400;
            6'd34: instruction = 16'h7650;   // XOR r3,r1,r2
            6'd35: instruction = 16'hA0C0;
            6'd36: instruction = 16'hF000;
            // sel 11: max(A,B); operands are 7-bit so A-B never overflows
            6'd48: instruction = 16'h1200;
            6'd49: instruction = 16'h2400;
            6'd50: instruction = 16'h4650;   // SUB r3,r1,r2
            6'd51: instruction = 16'hB036;   // BRN 54
            6'd52: instruction = 16'hA040;   // OUT r1
            6'd53: instruction = 16'hF000;
            6'd54: instruction = 16'hA080;   // OUT r2
            6'd55: instruction = 16'hF000;
            default: instruction = 16'h0000;
        endcase
    end

    assign reg_read_data1 = (rs1 == 3'd0) ? '0 : rf[rs1];
    assign reg_read_data2 = (rs2 == 3'd0) ? '0 : rf[rs2];

    always_comb begin
        alu_result = '0;
        wr_en      = 1'b1;
        flag_en    = 1'b0;
        ovf_next   = 1'b0;
        case (op)
            OP_LDA: alu_result = {{(DATA_W-7){1'b0}}, switches[6:0]};
            OP_LDB: alu_result = {{(DATA_W-7){1'b0}}, switches[13:7]};
            OP_ADD: begin
                alu_result = reg_read_data1 + reg_read_data2;
                flag_en    = 1'b1;
                ovf_next   = (reg_read_data1[DATA_W-1] == reg_read_data2[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != reg_read_data1[DATA_W-1]);
            end
            OP_SUB: begin
                alu_result = reg_read_data1 - reg_read_data2;
                flag_en    = 1'b1;
                ovf_next   = (reg_read_data1[DATA_W-1] != reg_read_data2[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != reg_read_data1[DATA_W-1]);
            end
            OP_AND: alu_result = reg_read_data1 & reg_read_data2;
            OP_OR:  alu_result = reg_read_data1 | reg_read_data2;
            OP_XOR: alu_result = reg_read_data1 ^ reg_read_data2;
            OP_MOV: alu_result = reg_read_data1;
            OP_LDI: alu_result = instruction[DATA_W-1:0];
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                rf[i] <= '0;
            negative_flag  <= 1'b0;
            overflow       <= 1'b0;
            display_output <= '0;
            halted         <= 1'b0;
        end else if (!halted) begin
            if (wr_en && rd != 3'd0)
                rf[rd] <= alu_result;
            if (flag_en) begin
                negative_flag <= alu_result[DATA_W-1];
                overflow      <= ovf_next;
            end
            if (op == OP_OUT)
                display_output <= reg_read_data1;
            if (op == OP_HALT)
                halted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_top.sv
// Scoreboard bench for cpu_top: each program run pushes its expected result,
// and a monitor pops and checks it when the CPU reaches HALT.
module tb_cpu_top;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] switches = '0;
    logic [7:0]  display_output;

    cpu_top dut (
        .clk            (clk),
        .reset          (reset),
        .switches       (switches),
        .display_output (display_output)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        int       disp;
        bit       chk_flags;
        int       neg;
        int       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_halted = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a rising halted marks the end of a program run.
    initial begin
        forever begin
            @(negedge clk);
            if (dut.halted && !prev_halted) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_halt", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_display"}, int'(display_output), e.disp);
                    if (e.chk_flags) begin
                        chk({e.name, "_neg"}, int'(dut.negative_flag), e.neg);
                        chk({e.name, "_ovf"}, int'(dut.overflow), e.ovf);
                    end
                end
            end
            prev_halted = dut.halted;
        end
    end

    task automatic do_reset(input logic [1:0] sel, input int a, input int b);
        switches = {sel, 7'(b), 7'(a)};
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pc", int'(dut.PC.pc), int'(sel) * 16);
        chk("reset_display", int'(display_output), 0);
        chk("reset_neg", int'(dut.negative_flag), 0);
        chk("reset_ovf", int'(dut.overflow), 0);
        reset = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 12 && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL halt_timeout: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input string name, input logic [1:0] sel, input int a, input int b,
                       input int disp, input bit chkf, input int neg, input int ovf);
        exp_t e;
        do_reset(sel, a, b);
        e.name = name; e.disp = disp; e.chk_flags = chkf; e.neg = neg; e.ovf = ovf;
        exp_q.push_back(e);
        repeat (6) @(negedge clk);
        chk({name, "_by6"}, int'(display_output), disp);
        wait_done();
    endtask

    initial begin
        // max(7,3): not taken, display stays 7 afterwards
        run("max_7_3", 2'b11, 7, 3, 7, 1'b1, 0, 0);
        repeat (5) @(negedge clk);
        chk("max_7_3_stable", int'(display_output), 7);

        // max(3,7): SUB goes negative, BRN taken to 54
        run("max_3_7", 2'b11, 3, 7, 7, 1'b1, 1, 0);
        chk("max_3_7_pc", int'(dut.PC.pc), 55);

        // 127+127 = 0xFE, signed overflow
        run("add_127_127", 2'b00, 127, 127, 8'hFE, 1'b1, 1, 1);

        // 3-7 = 0xFC, negative without overflow
        run("sub_3_7", 2'b01, 3, 7, 8'hFC, 1'b1, 1, 0);

        // 0x55 ^ 0x2A = 0x7F, then pc frozen on HALT at 36
        run("xor_55_2a", 2'b10, 8'h55, 8'h2A, 8'h7F, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_pc_frozen", int'(dut.PC.pc), 36);
        end
        chk("halt_display_frozen", int'(display_output), 8'h7F);

        // Reset mid-run after OUT, before HALT, then rerun
        do_reset(2'b00, 127, 127);
        repeat (4) @(negedge clk);
        chk("midrun_display", int'(display_output), 8'hFE);
        chk("midrun_neg", int'(dut.negative_flag), 1);
        run("rerun_add", 2'b00, 127, 127, 8'hFE, 1'b1, 1, 1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
